muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit that sits in the EX stage beside the
// single-cycle ALU. One radix-2 step is retired per clock: shift-add for the
// multiplies, restoring division for the divides. Operands are converted to
// magnitudes on acceptance and the sign correction is applied when the
// result register is loaded on entry to DONE.
//
// Optional feature (compile-time macro MULDIV_EARLY_OUT_EN):
//   When defined, divide-by-zero, signed division overflow and multiplies
//   with a zero operand skip the iteration phase and go straight to DONE,
//   so done rises the cycle after start with busy never asserted. When it
//   is undefined every operation takes the full WIDTH+1 cycles and those
//   special cases are resolved at the end of the iteration instead.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   operation request, accepted only in IDLE or DONE
//   flush   in   kills any in-flight operation (wins over start)
//   funct3  in   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   SrcA    in   rs1 operand (multiplicand / dividend)
//   SrcB    in   rs2 operand (multiplier / divisor)
//   busy    out  high while iterating (feeds the hazard unit)
//   done    out  one-cycle pulse, result valid
//   result  out  registered result, held until the next done
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t               state_reg;
   logic [CW-1:0]        counter_reg;
   logic [2:0]           op_reg;
   // Multiplicand magnitude for multiplies, divisor magnitude for divides.
   logic [WIDTH-1:0]     operand_reg;
   // Multiply: {partial product high, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0]   acc_reg;
   // Operand signs differ: negate product / quotient at the end.
   logic                 neg_res_reg;
   // Dividend was negative: remainder takes its sign.
   logic                 neg_rem_reg;
   logic                 div_zero_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [WIDTH-1:0]     result_reg;

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;

   // ------------------------------------------------------------------
   // Operand decode on the incoming request
   // ------------------------------------------------------------------
   logic             a_signed;
   logic             b_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             is_div_in;
   logic             div_zero_in;

   always_comb begin
      a_signed    = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                    (funct3 == OP_DIV)  || (funct3 == OP_REM);
      b_signed    = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                    (funct3 == OP_REM);
      a_neg       = a_signed && SrcA[WIDTH-1];
      b_neg       = b_signed && SrcB[WIDTH-1];
      // The most negative value negates to itself, which read as unsigned
      // is exactly its magnitude, so no extra datapath bit is needed.
      a_mag       = a_neg ? (~SrcA + 1'b1) : SrcA;
      b_mag       = b_neg ? (~SrcB + 1'b1) : SrcB;
      is_div_in   = funct3[2];
      div_zero_in = is_div_in && (SrcB == '0);
   end

   // ------------------------------------------------------------------
   // One radix-2 step
   // ------------------------------------------------------------------
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       mul_hi;
   logic [WIDTH:0]       shifted_hi;
   logic [WIDTH:0]       trial;
   logic [2*WIDTH-1:0]   step_acc;

   always_comb begin
      // Shift-add: conditionally add the multiplicand into the high half,
      // then shift the whole pair right, keeping the carry.
      add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, operand_reg};
      mul_hi  = acc_reg[0] ? add_sum : {1'b0, acc_reg[2*WIDTH-1:WIDTH]};

      // Restoring division: shift the pair left by one, try subtracting
      // the divisor from the top WIDTH+1 bits. The partial remainder is
      // always below the divisor, so the trial fits in WIDTH+1 bits and
      // its MSB is a valid sign.
      shifted_hi = acc_reg[2*WIDTH-1:WIDTH-1];
      trial      = shifted_hi - {1'b0, operand_reg};

      step_acc = '0;
      if (op_reg[2]) begin
         if (!trial[WIDTH]) begin
            step_acc = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = {shifted_hi[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc = {mul_hi, acc_reg[WIDTH-1:1]};
      end
   end

   // ------------------------------------------------------------------
   // Sign correction and result selection, applied to the last step
   // ------------------------------------------------------------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   final_result;

   always_comb begin
      prod_fix = neg_res_reg ? (~step_acc + 1'b1) : step_acc;
      quo_fix  = neg_res_reg ? (~step_acc[WIDTH-1:0] + 1'b1)
                             : step_acc[WIDTH-1:0];
      rem_fix  = neg_rem_reg ? (~step_acc[2*WIDTH-1:WIDTH] + 1'b1)
                             : step_acc[2*WIDTH-1:WIDTH];

      final_result = '0;
      case (op_reg)
         OP_MUL: begin
            final_result = prod_fix[WIDTH-1:0];
         end
         OP_MULH, OP_MULHSU, OP_MULHU: begin
            final_result = prod_fix[2*WIDTH-1:WIDTH];
         end
         OP_DIV, OP_DIVU: begin
            // A zero divisor makes every trial succeed, so the magnitude
            // quotient is all ones; the sign flip must not touch it.
            // Signed overflow needs no fixup: |min|/1 = min, signs agree.
            final_result = div_zero_reg ? '1 : quo_fix;
         end
         default: begin
            // REM/REMU: with a zero divisor the remainder is the dividend
            // magnitude, and re-applying the dividend sign restores SrcA
            // exactly. Signed overflow leaves a zero remainder.
            final_result = rem_fix;
         end
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   // ------------------------------------------------------------------
   // Early-out detection and the short-circuit result values
   // ------------------------------------------------------------------
   logic             ovf_in;
   logic             early_in;
   logic [WIDTH-1:0] early_result;

   always_comb begin
      ovf_in = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
               (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (SrcB == '1);
      early_in     = 1'b0;
      early_result = '0;
      if (is_div_in) begin
         if (div_zero_in) begin
            early_in     = 1'b1;
            early_result = funct3[1] ? SrcA : '1;
         end else if (ovf_in) begin
            early_in     = 1'b1;
            early_result = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
         end
      end else if ((SrcA == '0) || (SrcB == '0)) begin
         early_in     = 1'b1;
         early_result = '0;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         counter_reg  <= '0;
         op_reg       <= OP_MUL;
         operand_reg  <= '0;
         acc_reg      <= '0;
         neg_res_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div_zero_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         result_reg   <= '0;
      end else if (flush) begin
         // Abandon whatever is in flight; result keeps its last value.
         state_reg   <= IDLE;
         counter_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  op_reg       <= funct3;
                  counter_reg  <= '0;
                  neg_res_reg  <= a_neg ^ b_neg;
                  neg_rem_reg  <= a_neg;
                  div_zero_reg <= div_zero_in;
                  if (is_div_in) begin
                     operand_reg <= b_mag;
                     acc_reg     <= {{WIDTH{1'b0}}, a_mag};
                  end else begin
                     operand_reg <= a_mag;
                     acc_reg     <= {{WIDTH{1'b0}}, b_mag};
                  end
`ifdef MULDIV_EARLY_OUT_EN
                  if (early_in) begin
                     state_reg  <= DONE;
                     busy_reg   <= 1'b0;
                     done_reg   <= 1'b1;
                     result_reg <= early_result;
                  end else begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end
`else
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
`endif
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            RUN: begin
               acc_reg     <= step_acc;
               counter_reg <= counter_reg + CNT_ONE;
               if (counter_reg == LAST_ITER) begin
                  // Last step: load the corrected result on entry to DONE.
                  state_reg  <= DONE;
                  busy_reg   <= 1'b0;
                  done_reg   <= 1'b1;
                  result_reg <= final_result;
               end
            end

            default: begin
               state_reg   <= IDLE;
               counter_reg <= '0;
               busy_reg    <= 1'b0;
               done_reg    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int WIDTH = 32;
   localparam int N     = WIDTH;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks_total  = 0;
   int checks_passed = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Behavioural reference: plain 64-bit arithmetic and the RV32M rules.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = '0;
      case (f)
         3'd0: begin r = sa * sb; return r[31:0];  end
         3'd1: begin r = sa * sb; return r[63:32]; end
         3'd2: begin r = sa * ub; return r[63:32]; end
         3'd3: begin r = ua * ub; return r[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            r = sa / sb; return r[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            r = ua / ub; return r[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            r = sa % sb; return r[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            r = ua % ub; return r[31:0];
         end
      endcase
   endfunction

   function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2]) return (b == 32'd0) ||
                       ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      return (a == 32'd0) || (b == 32'd0);
`else
      return (f != f) || (a != a) || (b != b);
`endif
   endfunction

   // Counts cycles from the current one until done is seen (bounded).
   task automatic wait_done(input int cyc_in, output int cyc, output int busy_cnt);
      cyc = cyc_in;
      busy_cnt = 0;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int cyc, busy_cnt, exp_cyc;
      @(negedge clk);
      funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, cyc, busy_cnt);
      exp_cyc = is_early(f, a, b) ? 1 : N + 1;
      check({name, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
      check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
      check({name, " result"}, result, exp);
      $display("op %s f=%0d a=%h b=%h result=%h done_at=t+%0d", name, f, a, b, result, cyc);
      @(negedge clk);
      check({name, " done_pulse_len"}, {31'b0, done}, 32'd0);
      check({name, " result_held"}, result, exp);
   endtask

   // Watches for stray done pulses over a window.
   task automatic no_done_window(input string name, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         if (done === 1'b1) pulses++;
         @(negedge clk);
      end
      check({name, " stray_done"}, 32'(pulses), 32'd0);
   endtask

   vec_t vecs[16];

   initial begin
      int cyc, busy_cnt;
      logic [31:0] specials[5];
      logic [2:0]  rf;
      logic [31:0] ra, rb;

      vecs[0]  = '{"MUL_7x-3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"MULH_7x-3",     3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
      vecs[2]  = '{"MULHU_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{"MULHSU_-1x2",   3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
      vecs[4]  = '{"DIV_-7/2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vecs[5]  = '{"REM_-7/2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[6]  = '{"DIVU_100/7",    3'd5, 32'd100,        32'd7,         32'd14};
      vecs[7]  = '{"REMU_100/7",    3'd7, 32'd100,        32'd7,         32'd2};
      vecs[8]  = '{"DIV_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[9]  = '{"REM_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      vecs[10] = '{"DIVU_5/0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[11] = '{"REMU_5/0",      3'd7, 32'd5,          32'd0,         32'd5};
      vecs[12] = '{"DIV_-5/0",      3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
      vecs[13] = '{"REM_-5/0",      3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
      vecs[14] = '{"MUL_0x123",     3'd0, 32'd0,          32'd123,       32'd0};
      vecs[15] = '{"MULH_min^2",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};

      specials[0] = 32'd0;
      specials[1] = 32'h8000_0000;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'd1;
      specials[4] = 32'h7FFF_FFFF;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; SrcA = '0; SrcB = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Flush mid-DIV at t+10: idle at t+11, no done, result keeps 14.
      run_op("DIVU_pre_flush", 3'd5, 32'd100, 32'd7, 32'd14);
      @(negedge clk);
      funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", {31'b0, busy}, 32'd0);
      check("flush done", {31'b0, done}, 32'd0);
      check("flush result", result, 32'd14);
      no_done_window("flush", 40);
      check("flush result_after", result, 32'd14);
      $display("op FLUSH of DIV at t+10 result=%h", result);

      // flush and start together: flush wins, nothing launches.
      @(negedge clk);
      funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", {31'b0, busy}, 32'd0);
      no_done_window("flush+start", 40);
      $display("op FLUSH+START result=%h", result);

      // rst at t+5 of a MUL: everything clears next cycle.
      @(negedge clk);
      funct3 = 3'd0; SrcA = 32'd6; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid busy", {31'b0, busy}, 32'd0);
      check("rst_mid done", {31'b0, done}, 32'd0);
      check("rst_mid result", result, 32'd0);
      no_done_window("rst_mid", 40);
      $display("op RST at t+5 result=%h", result);

      // start at t+3 while busy is ignored.
      @(negedge clk);
      funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, cyc, busy_cnt);
      check("busy_start done_cycle", 32'(cyc), 32'(N + 1));
      check("busy_start result", result, 32'd14);
      @(negedge clk);
      no_done_window("busy_start", 40);
      $display("op START_WHILE_BUSY result=%h done_at=t+%0d", result, cyc);

      // Back-to-back: start DIVU 9/3 in the DONE cycle of a MUL.
      @(negedge clk);
      funct3 = 3'd0; SrcA = 32'd6; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, cyc, busy_cnt);
      check("b2b mul done_cycle", 32'(cyc), 32'(N + 1));
      check("b2b mul result", result, 32'd42);
      funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b div busy", {31'b0, busy}, 32'd1);
      wait_done(1, cyc, busy_cnt);
      check("b2b div done_cycle", 32'(cyc), 32'(N + 1));
      check("b2b div result", result, 32'd3);
      $display("op BACK_TO_BACK MUL then DIVU result=%h done_at=t+%0d", result, cyc);

      // Randomized operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 5) == 0) rb = rb & 32'h0000_00FF;
         run_op($sformatf("rand%0d", i), rf, ra, rb, ref_model(rf, ra, rb));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
